xor_encode_sched: RTL and testbench

Byte-serial scheduler that shares one 8-bit XOR lane between two 80-bit record requesters. It arbitrates round-robin between requester 0 and requester 1, captures the granted record, and encodes it byte by byte against a loaded 64-bit key. Key bytes are reused cyclically, so record byte k uses key byte k mod 8. The encoded record is presented on a single valid/ready output port. The block sits between the ballot record sources and the storage/transmit path.

---
 rtl/xor_encode_sched_if.sv | 27 ++
 rtl/xor_encode_sched.sv | 125 ++++++++++++
 tb/tb_xor_encode_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_encode_sched_if.sv
// Record/key/output bundle for the shared XOR encode lane.
// slave = encoder side, master = requesters plus downstream sink.
interface xor_encode_sched_if;
    logic        key_wr;
    logic [63:0] key_in;
    logic        key_ready;
    logic [1:0]  in_valid;
    logic [79:0] in_data0;
    logic [79:0] in_data1;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic [79:0] out_data;
    logic        out_src;
    logic        out_ready;
    logic        busy;
    logic [15:0] rec_cnt;

    modport master (
        output key_wr, key_in, in_valid, in_data0, in_data1, out_ready,
        input  key_ready, in_ready, out_valid, out_data, out_src, busy, rec_cnt
    );

    modport slave (
        input  key_wr, key_in, in_valid, in_data0, in_data1, out_ready,
        output key_ready, in_ready, out_valid, out_data, out_src, busy, rec_cnt
    );
endinterface

// File: rtl/xor_encode_sched.sv
// Round-robin two-requester scheduler feeding one byte-serial XOR lane; 10 ENC cycles per 80-bit record.
// Output holds in OUT until out_ready; nothing is accepted while busy.
module xor_encode_sched (
    input logic               clk,
    input logic               rst_n,
    xor_encode_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        key_loaded;
    logic [63:0] key;
    logic [3:0]  cnt;
    logic        last;
    logic [79:0] rec;
    logic [79:0] out_data_q;
    logic        out_src_q;
    logic [15:0] rec_cnt_q;

    logic        any_valid;
    logic        grant;
    logic        accept;
    logic        deliver;
    logic [1:0]  in_ready_c;
    logic        key_ready_c;
    logic        out_valid_c;
    logic        busy_c;
    logic [2:0]  kidx;
    logic [3:0]  ridx;

    // Byte 0 is the most significant byte of both record and key.
    always_comb begin
        kidx = 3'd7 - cnt[2:0];
        ridx = 4'd9 - cnt;
    end

    // On a tie, the requester not granted last time wins.
    always_comb begin
        any_valid = |bus.in_valid;
        grant     = (bus.in_valid == 2'b11) ? ~last : bus.in_valid[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        deliver     = 1'b0;
        in_ready_c  = 2'b00;
        key_ready_c = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state)
            IDLE: begin
                key_ready_c = 1'b1;
                if (!bus.key_wr && key_loaded && any_valid) begin
                    accept     = 1'b1;
                    in_ready_c = grant ? 2'b10 : 2'b01;
                    state_nxt  = ENC;
                end
            end
            ENC: begin
                busy_c = 1'b1;
                if (cnt == 4'd9) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_loaded <= 1'b0;
            key        <= '0;
            cnt        <= '0;
            last       <= 1'b1;
            rec        <= '0;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            rec_cnt_q  <= '0;
        end else begin
            // Key writes only land in IDLE, so a record in flight keeps its key.
            if (state == IDLE && bus.key_wr) begin
                key        <= bus.key_in;
                key_loaded <= 1'b1;
            end
            if (accept) begin
                rec       <= grant ? bus.in_data1 : bus.in_data0;
                out_src_q <= grant;
                last      <= grant;
                cnt       <= '0;
            end else if (state == ENC) begin
                out_data_q[{ridx, 3'b000} +: 8] <= rec[{ridx, 3'b000} +: 8] ^ key[{kidx, 3'b000} +: 8];
                cnt <= cnt + 4'd1;
            end
            if (deliver && rec_cnt_q != 16'hFFFF) begin
                rec_cnt_q <= rec_cnt_q + 16'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.key_ready = key_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.rec_cnt   = rec_cnt_q;
endmodule

// File: tb/tb_xor_encode_sched.sv
// Bench for xor_encode_sched: directed scenarios plus randomized records against a byte-level model.
module tb_xor_encode_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    xor_encode_sched_if bus ();

    xor_encode_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc_count  = 0;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    logic [63:0] m_key;
    bit          m_last;
    int          m_rec_cnt;

    function automatic logic [79:0] ref_enc(input logic [79:0] d, input logic [63:0] k);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[79-8*i -: 8] = d[79-8*i -: 8] ^ k[63-8*(i%8) -: 8];
        end
        return r;
    endfunction

    function automatic logic [79:0] rnd80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.key_wr    = 1'b0;
        bus.key_in    = '0;
        bus.in_valid  = 2'b00;
        bus.in_data0  = '0;
        bus.in_data1  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
        m_last    = 1'b1;
        m_rec_cnt = 0;
        m_key     = '0;
    endtask

    task automatic load_key(input logic [63:0] k);
        bus.key_wr = 1'b1;
        bus.key_in = k;
        tick();
        bus.key_wr = 1'b0;
        m_key      = k;
    endtask

    // Raises in_valid and returns the grant seen; data is scrambled after the accept edge.
    task automatic wait_accept(input logic [1:0] mask, input logic [79:0] d0, input logic [79:0] d1,
                               output int idx, output logic [1:0] seen, output bit ok, output int acc_cyc);
        bus.in_valid = mask;
        bus.in_data0 = d0;
        bus.in_data1 = d1;
        ok = 1'b0; idx = -1; seen = 2'b00; acc_cyc = -1;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (bus.in_ready != 2'b00) begin
                seen = bus.in_ready;
                idx  = bus.in_ready[1] ? 1 : 0;
                ok   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        acc_cyc      = cyc_count;
        bus.in_valid = 2'b00;
        bus.in_data0 = rnd80();
        bus.in_data1 = rnd80();
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.out_valid, bus.out_src, bus.busy, bus.key_ready, bus.in_ready} !== 6'b000100) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000100", {bus.out_valid, bus.out_src, bus.busy, bus.key_ready, bus.in_ready});
        end
        vectors++;
        if (bus.out_data !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_out_data got %h want 0", bus.out_data);
        end
        vectors++;
        if (bus.rec_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_rec_cnt got %0d want 0", bus.rec_cnt);
        end
    endtask

    task automatic test_basic_encode();
        int idx, cyc, acc;
        logic [1:0] seen;
        bit ok;
        do_reset();
        load_key(64'h0123456789ABCDEF);
        bus.out_ready = 1'b1;
        wait_accept(2'b01, 80'h0, rnd80(), idx, seen, ok, acc);
        vectors++;
        if (!ok || idx != 0) begin
            miscompares++;
            $display("FAIL basic_grant got %0d ok=%0b want 0", idx, ok);
        end
        wait_out(cyc);
        vectors++;
        if (cyc != 10) begin
            miscompares++;
            $display("FAIL basic_latency got %0d want 10", cyc);
        end
        vectors++;
        if (bus.out_data !== 80'h0123456789ABCDEF0123) begin
            miscompares++;
            $display("FAIL basic_data got %h want 0123456789abcdef0123", bus.out_data);
        end
        vectors++;
        if (bus.out_src !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_src got %b want 0", bus.out_src);
        end
        tick();
        vectors++;
        if (bus.rec_cnt !== 16'd1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_rec_cnt got %0d busy=%b want 1 busy=0", bus.rec_cnt, bus.busy);
        end
    endtask

    task automatic test_all_ones();
        int idx, cyc, acc;
        logic [1:0] seen;
        bit ok;
        wait_accept(2'b10, rnd80(), {80{1'b1}}, idx, seen, ok, acc);
        vectors++;
        if (!ok || idx != 1) begin
            miscompares++;
            $display("FAIL ones_grant got %0d ok=%0b want 1", idx, ok);
        end
        wait_out(cyc);
        vectors++;
        if (bus.out_data !== 80'hFEDCBA9876543210FEDC || bus.out_src !== 1'b1) begin
            miscompares++;
            $display("FAIL ones_data got %h src=%b want fedcba9876543210fedc src=1", bus.out_data, bus.out_src);
        end
        tick();
        vectors++;
        if (bus.rec_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL ones_rec_cnt got %0d want 2", bus.rec_cnt);
        end
    endtask

    task automatic test_round_robin();
        int idx, cyc, acc, prev_acc;
        int exp_order[4] = '{0, 1, 0, 1};
        logic [1:0] seen;
        logic [79:0] d0, d1, exp;
        bit ok;
        do_reset();
        load_key(rnd64());
        bus.out_ready = 1'b1;
        prev_acc = 0;
        for (int r = 0; r < 4; r++) begin
            d0 = rnd80();
            d1 = rnd80();
            wait_accept(2'b11, d0, d1, idx, seen, ok, acc);
            vectors++;
            if (!ok || idx != exp_order[r] || seen !== (exp_order[r] == 1 ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d got idx=%0d in_ready=%b want %0d one-hot", r, idx, seen, exp_order[r]);
            end
            if (r > 0) begin
                vectors++;
                if (acc - prev_acc != 12) begin
                    miscompares++;
                    $display("FAIL rr_interval_%0d got %0d want 12", r, acc - prev_acc);
                end
            end
            prev_acc = acc;
            exp = ref_enc(exp_order[r] == 1 ? d1 : d0, m_key);
            wait_out(cyc);
            vectors++;
            if (bus.out_data !== exp || bus.out_src !== exp_order[r][0]) begin
                miscompares++;
                $display("FAIL rr_data_%0d got %h src=%b want %h src=%0d", r, bus.out_data, bus.out_src, exp, exp_order[r]);
            end
            tick();
        end
        m_last = 1'b1;
    endtask

    task automatic test_backpressure();
        int idx, cyc, acc;
        logic [1:0] seen;
        logic [79:0] d, exp;
        bit ok;
        bus.out_ready = 1'b0;
        d = rnd80();
        exp = ref_enc(d, m_key);
        wait_accept(2'b01, d, rnd80(), idx, seen, ok, acc);
        wait_out(cyc);
        vectors++;
        if (!ok || idx != 0 || cyc != 10) begin
            miscompares++;
            $display("FAIL bp_setup got idx=%0d lat=%0d want 0 10", idx, cyc);
        end
        bus.in_valid = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if ({bus.out_valid, bus.out_src, bus.in_ready, bus.key_ready} !== 5'b10000 || bus.out_data !== exp) begin
                miscompares++;
                $display("FAIL bp_stall_%0d got flags=%b data=%h want 10000 %h", i,
                         {bus.out_valid, bus.out_src, bus.in_ready, bus.key_ready}, bus.out_data, exp);
            end
        end
        bus.in_valid  = 2'b00;
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if ({bus.out_valid, bus.busy, bus.key_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL bp_release got %b want 001", {bus.out_valid, bus.busy, bus.key_ready});
        end
    endtask

    task automatic test_key_gating();
        int idx, cyc, acc, kw_cyc;
        logic [1:0] seen;
        logic [63:0] k1, k2;
        logic [79:0] d, d2;
        bit ok;
        do_reset();
        bus.in_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 2'b00 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL nokey_ready_%0d got %b busy=%b want 00 0", i, bus.in_ready, bus.busy);
            end
            tick();
        end
        bus.in_valid = 2'b00;
        k1 = rnd64();
        k2 = rnd64() ^ 64'h1;
        load_key(k1);
        bus.out_ready = 1'b1;
        d = rnd80();
        wait_accept(2'b01, d, rnd80(), idx, seen, ok, acc);
        bus.key_wr = 1'b1;
        bus.key_in = k2;
        #1;
        vectors++;
        if (bus.key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL enc_key_ready got %b want 0", bus.key_ready);
        end
        tick(); tick(); tick();
        bus.key_wr = 1'b0;
        wait_out(cyc);
        vectors++;
        if (!ok || bus.out_data !== ref_enc(d, k1)) begin
            miscompares++;
            $display("FAIL enc_old_key got %h want %h", bus.out_data, ref_enc(d, k1));
        end
        tick();
        d2 = rnd80();
        bus.key_wr   = 1'b1;
        bus.key_in   = k2;
        bus.in_valid = 2'b01;
        bus.in_data0 = d2;
        #1;
        vectors++;
        if (bus.in_ready !== 2'b00 || bus.key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL keywr_priority got in_ready=%b key_ready=%b want 00 1", bus.in_ready, bus.key_ready);
        end
        tick();
        bus.key_wr = 1'b0;
        m_key  = k2;
        kw_cyc = cyc_count;
        wait_accept(2'b01, d2, rnd80(), idx, seen, ok, acc);
        vectors++;
        if (!ok || acc != kw_cyc + 1) begin
            miscompares++;
            $display("FAIL keywr_grant_delay got %0d want 1", acc - kw_cyc);
        end
        wait_out(cyc);
        vectors++;
        if (bus.out_data !== ref_enc(d2, k2)) begin
            miscompares++;
            $display("FAIL keywr_new_key got %h want %h", bus.out_data, ref_enc(d2, k2));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int idx, cyc, acc;
        logic [1:0] seen, ready_seen;
        logic valid_seen;
        bit ok;
        do_reset();
        load_key(rnd64());
        bus.out_ready = 1'b1;
        wait_accept(2'b01, rnd80(), rnd80(), idx, seen, ok, acc);
        wait_out(cyc);
        tick();
        wait_accept(2'b10, rnd80(), rnd80(), idx, seen, ok, acc);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({bus.out_valid, bus.out_src, bus.busy, bus.key_ready, bus.in_ready} !== 6'b000100) begin
            miscompares++;
            $display("FAIL midrst_flags got %b want 000100", {bus.out_valid, bus.out_src, bus.busy, bus.key_ready, bus.in_ready});
        end
        vectors++;
        if (bus.out_data !== 80'h0 || bus.rec_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_regs got data=%h cnt=%0d want 0 0", bus.out_data, bus.rec_cnt);
        end
        bus.in_valid = 2'b11;
        ready_seen = 2'b00;
        valid_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            ready_seen |= bus.in_ready;
            valid_seen |= bus.out_valid;
            tick();
        end
        bus.in_valid = 2'b00;
        vectors++;
        if (ready_seen !== 2'b00 || valid_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_key got in_ready=%b out_valid=%b want 00 0", ready_seen, valid_seen);
        end
    endtask

    task automatic test_random();
        int idx, cyc, acc, exp_g;
        logic [1:0] seen, mask;
        logic [79:0] d0, d1, exp;
        bit ok;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            if (n == 0 || $urandom_range(0, 2) == 0) load_key(rnd64());
            mask  = 2'($urandom_range(1, 3));
            d0    = rnd80();
            d1    = rnd80();
            exp_g = (mask == 2'b11) ? (m_last ? 0 : 1) : (mask[1] ? 1 : 0);
            exp   = ref_enc(exp_g == 1 ? d1 : d0, m_key);
            bus.out_ready = 1'b0;
            wait_accept(mask, d0, d1, idx, seen, ok, acc);
            m_last = (exp_g == 1);
            vectors++;
            if (!ok || idx != exp_g) begin
                miscompares++;
                $display("FAIL rnd_grant_%0d got %0d want %0d", n, idx, exp_g);
            end
            wait_out(cyc);
            vectors++;
            if (cyc != 10 || bus.out_data !== exp || bus.out_src !== exp_g[0]) begin
                miscompares++;
                $display("FAIL rnd_out_%0d got lat=%0d %h src=%b want 10 %h src=%0d", n, cyc, bus.out_data, bus.out_src, exp, exp_g);
            end
            for (int s = $urandom_range(0, 3); s > 0; s--) tick();
            bus.out_ready = 1'b1;
            tick();
            m_rec_cnt++;
            vectors++;
            if (bus.rec_cnt !== 16'(m_rec_cnt)) begin
                miscompares++;
                $display("FAIL rnd_rec_cnt_%0d got %0d want %0d", n, bus.rec_cnt, m_rec_cnt);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_encode();
        test_all_ones();
        test_round_robin();
        test_backpressure();
        test_key_gating();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
